// File: rtl/usr_cmd_sequencer_if.sv
// Command channel into the shift-register sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_len/cmd_data are meaningful only while
// cmd_valid is high, and the producer keeps them stable until the transfer.
interface usr_cmd_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic [WIDTH-1:0] cmd_data;

   modport master (output cmd_valid, cmd_op, cmd_len, cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_len, cmd_data, output cmd_ready);
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Expands one command word into a cycle-by-cycle stream of sel/shift_r/
// shift_l/d controls for a downstream universal shift register.
module usr_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   usr_cmd_sequencer_if.slave cmd,
   output logic [1:0]       sel_o,
   output logic             shift_r_o,
   output logic             shift_l_o,
   output logic [WIDTH-1:0] d_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       sel_q, sel_d;
   logic             shr_q, shr_d;
   logic             shl_q, shl_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             done_q, done_d;

   // Step selected for the control registers at the coming edge.
   logic             step_act;
   logic [1:0]       step_op;
   logic [WIDTH-1:0] step_data;
   logic [CNT_W-1:0] step_idx;
   logic [WIDTH-1:0] step_shifted;
   logic [CNT_W-1:0] eff_len;

   // LOAD always lasts one cycle; a zero length behaves as one.
   assign eff_len = (cmd.cmd_op == OP_LOAD || cmd.cmd_len == '0) ? CNT_W'(1) : cmd.cmd_len;

   // Serial bit for a step; steps beyond the data width shift in zeros.
   assign step_shifted = step_data >> step_idx;

   // Next-state, counter and next-control computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      op_d      = op_q;
      data_d    = data_q;
      done_d    = 1'b0;
      step_act  = 1'b0;
      step_op   = 2'b00;
      step_data = '0;
      step_idx  = '0;
      sel_d     = 2'b00;
      shr_d     = 1'b0;
      shl_d     = 1'b0;
      dout_d    = '0;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               op_d      = cmd.cmd_op;
               len_d     = eff_len;
               data_d    = cmd.cmd_data;
               cnt_d     = '0;
               state_d   = RUN;
               step_act  = 1'b1;
               step_op   = cmd.cmd_op;
               step_data = cmd.cmd_data;
               step_idx  = '0;
            end
         end
         RUN: begin
            if (cnt_q == len_q - CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               step_act  = 1'b1;
               step_op   = op_q;
               step_data = data_q;
               step_idx  = cnt_d;
            end
         end
         default: state_d = IDLE;
      endcase
      if (step_act) begin
         sel_d  = step_op;
         shr_d  = (step_op == OP_SHR) && step_shifted[0];
         shl_d  = (step_op == OP_SHL) && step_shifted[0];
         dout_d = (step_op == OP_LOAD) ? step_data : '0;
      end
   end

   // State, command latches and registered controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= CNT_W'(1);
         op_q    <= 2'b00;
         data_q  <= '0;
         sel_q   <= 2'b00;
         shr_q   <= 1'b0;
         shl_q   <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         op_q    <= op_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         shr_q   <= shr_d;
         shl_q   <= shl_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
      end
   end

   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy_o        = (state_q == RUN);
   assign dbg_state_o   = state_q;
   assign sel_o         = sel_q;
   assign shift_r_o     = shr_q;
   assign shift_l_o     = shl_q;
   assign d_o           = dout_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: directed scenarios plus randomized commands,
// compared cycle by cycle against a queue-based reference model, with a
// reference 4-bit universal shift register hooked to the control outputs.
module tb_usr_cmd_sequencer;

   typedef struct packed {
      logic [1:0] sel;
      logic       sr;
      logic       sl;
      logic [3:0] d;
      logic       busy;
      logic       done;
      logic       ready;
   } ctl_t;

   localparam ctl_t IDLE_W = '{sel: 2'b00, sr: 1'b0, sl: 1'b0, d: 4'h0,
                              busy: 1'b0, done: 1'b0, ready: 1'b1};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] sel_o;
   logic       shift_r_o, shift_l_o, busy_o, done_o, dbg_state_o;
   logic [3:0] d_o;
   logic [3:0] ref_q;

   int checks = 0;
   int errors = 0;

   logic [10:0] exp_q[$];
   ctl_t        cur = IDLE_W;
   logic [3:0]  model_q = 4'h0;
   bit          acc;

   usr_cmd_sequencer_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

   usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd_if.slave),
      .sel_o       (sel_o),
      .shift_r_o   (shift_r_o),
      .shift_l_o   (shift_l_o),
      .d_o         (d_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .dbg_state_o (dbg_state_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Downstream universal shift register fed by the DUT controls
   always @(posedge clk) begin
      if (rst) ref_q <= 4'h0;
      else begin
         case (sel_o)
            2'b01:   ref_q <= {shift_r_o, ref_q[3:1]};
            2'b10:   ref_q <= {ref_q[2:0], shift_l_o};
            2'b11:   ref_q <= d_o;
            default: ref_q <= ref_q;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: on acceptance, list every control cycle the command produces,
   // then its completion cycle, and compute the final register value.
   task automatic plan(input logic [1:0] op, input logic [2:0] len, input logic [3:0] data);
      int   n;
      ctl_t w;
      logic b;
      n = (op == 2'b11 || len == 3'd0) ? 1 : int'(len);
      for (int i = 0; i < n; i++) begin
         b = (i < 4) ? data[i] : 1'b0;
         w = IDLE_W;
         w.ready = 1'b0;
         w.busy  = 1'b1;
         w.sel   = op;
         w.sr    = (op == 2'b01) ? b : 1'b0;
         w.sl    = (op == 2'b10) ? b : 1'b0;
         w.d     = (op == 2'b11) ? data : 4'h0;
         exp_q.push_back(w);
         case (op)
            2'b01:   model_q = {b, model_q[3:1]};
            2'b10:   model_q = {model_q[2:0], b};
            2'b11:   model_q = data;
            default: model_q = model_q;
         endcase
      end
      w = IDLE_W;
      w.done = 1'b1;
      exp_q.push_back(w);
   endtask

   // One clock: advance the model at the edge, compare just after it
   task automatic cycle();
      ctl_t obs;
      @(posedge clk);
      acc = 1'b0;
      if (rst) begin
         exp_q.delete();
         model_q = 4'h0;
         cur = IDLE_W;
      end else begin
         if (cur.ready && cmd_if.cmd_valid) begin
            acc = 1'b1;
            plan(cmd_if.cmd_op, cmd_if.cmd_len, cmd_if.cmd_data);
         end
         cur = (exp_q.size() > 0) ? ctl_t'(exp_q.pop_front()) : IDLE_W;
      end
      #1;
      obs = {sel_o, shift_r_o, shift_l_o, d_o, busy_o, done_o, cmd_if.cmd_ready};
      check("ctl", 32'(obs), 32'(cur));
      check("state", 32'(dbg_state_o), 32'(cur.busy));
      if (cur.done) check("reg_q", 32'(ref_q), 32'(model_q));
   endtask

   // Idle cycles; command fields wander with valid low and must be ignored
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         cmd_if.cmd_valid = 1'b0;
         cmd_if.cmd_op    = 2'($urandom_range(0, 3));
         cmd_if.cmd_len   = 3'($urandom_range(0, 7));
         cmd_if.cmd_data  = 4'($urandom_range(0, 15));
         cycle();
      end
   endtask

   // Present a command and hold it until the model says it was taken
   task automatic send(input logic [1:0] op, input logic [2:0] len, input logic [3:0] data);
      bit taken = 1'b0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_len   = len;
      cmd_if.cmd_data  = data;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (acc) begin
            taken = 1'b1;
            break;
         end
      end
      if (!taken) check("accept_timeout", 32'd0, 32'd1);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic reset_pulse(input bit with_valid);
      rst = 1'b1;
      cmd_if.cmd_valid = with_valid;
      cmd_if.cmd_op    = 2'b11;
      cmd_if.cmd_len   = 3'd1;
      cmd_if.cmd_data  = 4'h9;
      cycle();
      rst = 1'b0;
      cmd_if.cmd_valid = 1'b0;
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_len   = 3'd0;
      cmd_if.cmd_data  = 4'h0;
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      idle(2);

      // LOAD ignores its length
      send(2'b11, 3'd5, 4'hA);
      idle(3);
      // Shift right four bits into a cleared register
      reset_pulse(1'b0);
      send(2'b01, 3'd4, 4'b1011);
      idle(6);
      // Shift left two bits, then a zero-length HOLD
      reset_pulse(1'b0);
      send(2'b10, 3'd2, 4'b0010);
      idle(4);
      send(2'b00, 3'd0, 4'hF);
      idle(3);
      // Back-to-back with valid held high
      send(2'b11, 3'd0, 4'h5);
      send(2'b01, 3'd1, 4'b0001);
      idle(4);
      // Reset at step 2 of a long shift
      send(2'b01, 3'd6, 4'b1010);
      cycle();
      cycle();
      reset_pulse(1'b0);
      idle(3);
      // Reset wins over a simultaneous command
      reset_pulse(1'b1);
      idle(2);
      // Maximum length
      send(2'b01, 3'd7, 4'hF);
      idle(9);

      // Randomized traffic with occasional resets
      for (int t = 0; t < 80; t++) begin
         idle($urandom_range(0, 2));
         if ($urandom_range(0, 11) == 0) reset_pulse(1'($urandom_range(0, 1)));
         else send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)));
      end
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
